// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared state codes, width defaults and length clamp for the ram loader
package ram_loader_pkg;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_WRITE  = 2'd1;
  localparam state_t S_VERIFY = 2'd2;
  localparam state_t S_DONE   = 2'd3;
  function automatic logic [31:0] clamp_len(input logic [31:0] len, input int unsigned aw);
    logic [31:0] depth;
    depth = 32'd1 << aw;
    return (len > depth) ? depth : len;
  endfunction
endpackage

// File: rtl/ram_loader_sum.sv
// ram_loader_sum: modulo-2^W running sum with synchronous clear and enable
module ram_loader_sum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);
  logic [W-1:0] sum_d, sum_q;
  always_comb sum_d = clr ? '0 : en ? sum_q + din : sum_q;
  always_ff @(posedge clk) begin
    if (!reset_n) sum_q <= '0;
    else sum_q <= sum_d;
  end
  assign sum = sum_q;
endmodule

// File: rtl/ram_loader.sv
// ram_loader: streams bytes into consecutive memory words, then optionally verifies them by checksum
module ram_loader import ram_loader_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit VERIFY     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic                  mem_ce,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  state_t state_d, state_q;
  logic [ADDR_WIDTH-1:0] base_d, base_q, addr_d, addr_q;
  logic [CW-1:0] n_d, n_q, wcount_d, wcount_q, rcount_d, rcount_q, n_start, rnext;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q, wsum, rsum, rsum_last;
  logic we_d, we_q, re_d, re_q, ce_d, ce_q, busy_d, busy_q, done_d, done_q, error_d, error_q;
  logic accept, clr;
  assign n_start   = CW'(clamp_len(32'(length), ADDR_WIDTH));
  assign in_ready  = (state_q == S_WRITE) && (wcount_q < n_q);
  assign accept    = in_ready && in_valid;
  assign clr       = (state_q == S_IDLE) && start;
  assign rnext     = rcount_q + CNT_ONE;
  // the last read's data is folded in combinationally so error lines up with done
  assign rsum_last = rsum + mem_rdata;
  ram_loader_sum #(.W(DATA_WIDTH)) u_wsum (
    .clk(clk), .reset_n(reset_n), .clr(clr), .en(accept), .din(in_data), .sum(wsum)
  );
  ram_loader_sum #(.W(DATA_WIDTH)) u_rsum (
    .clk(clk), .reset_n(reset_n), .clr(clr), .en(state_q == S_VERIFY), .din(mem_rdata), .sum(rsum)
  );
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    n_d      = n_q;
    wcount_d = wcount_q;
    rcount_d = rcount_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    case (state_q)
      S_IDLE: if (start) begin
        base_d   = base_addr;
        n_d      = n_start;
        wcount_d = '0;
        rcount_d = '0;
        error_d  = 1'b0;
        state_d  = (n_start == '0) ? S_DONE : S_WRITE;
        busy_d   = (n_start != '0);
        done_d   = (n_start == '0);
      end
      S_WRITE: if (accept) begin
        wcount_d = wcount_q + CNT_ONE;
        we_d     = 1'b1;
        addr_d   = base_q + wcount_q[ADDR_WIDTH-1:0];
        wdata_d  = in_data;
      end else if (wcount_q == n_q) begin
        state_d = VERIFY ? S_VERIFY : S_DONE;
        re_d    = VERIFY;
        addr_d  = base_q;
        busy_d  = VERIFY;
        done_d  = !VERIFY;
      end
      S_VERIFY: begin
        rcount_d = rnext;
        if (rnext == n_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          error_d = (rsum_last != wsum);
        end else begin
          re_d   = 1'b1;
          addr_d = base_q + rnext[ADDR_WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
    ce_d = we_d | re_d;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      n_q      <= '0;
      wcount_q <= '0;
      rcount_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      ce_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      n_q      <= n_d;
      wcount_q <= wcount_d;
      rcount_q <= rcount_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      ce_q     <= ce_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end
  assign mem_address  = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_write_en = we_q;
  assign mem_read_en  = re_q;
  assign mem_ce       = ce_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: randomized loads against a transaction-level model of the loader
module tb_ram_loader;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0] base_addr = '0, in_data = '0;
  logic [8:0] length = '0;
  logic in_ready, mem_write_en, mem_read_en, mem_ce, busy, done, error;
  logic [7:0] mem_address, mem_wdata, mem_rdata;
  int total = 0, bad = 0, cyc = 0, busy_cnt = 0, last_done_rel = 0;
  bit corrupt = 1'b0;
  logic err_at_done = 1'b0;
  logic [7:0] mem [256];
  int w_addr[$], w_data[$], w_cyc[$], r_addr[$], r_cyc[$], done_cyc[$];
  int preset[$];

  ram_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_ce(mem_ce), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (mem_write_en) mem[mem_address] <= mem_wdata;
  assign mem_rdata = mem[mem_address] ^ {7'b0, corrupt && mem_address == 8'h11};

  always @(negedge clk) begin
    if (mem_write_en) begin w_addr.push_back(int'(mem_address)); w_data.push_back(int'(mem_wdata)); w_cyc.push_back(cyc); end
    if (mem_read_en) begin r_addr.push_back(int'(mem_address)); r_cyc.push_back(cyc); end
    if (done) begin done_cyc.push_back(cyc); err_at_done = error; end
    if (busy) busy_cnt++;
    total++;
    if (mem_ce !== (mem_write_en | mem_read_en) || (mem_write_en && mem_read_en)) begin
      bad++;
      $display("FAIL strobe_excl: ce=%b we=%b re=%b, need ce=we|re and not both", mem_ce, mem_write_en, mem_read_en);
    end
  end

  task automatic clear_log();
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    r_addr.delete(); r_cyc.delete(); done_cyc.delete();
    busy_cnt = 0;
  endtask

  task automatic do_load(input logic [7:0] base, input logic [8:0] len, input int stall_lo,
                         input int stall_hi, input int stall_pct, input bit poke);
    int n, idx, t0, k, guard, last_acc, exp_done, ws, rs;
    int bytes[$], acc_cyc[$];
    logic exp_err;
    n = (len > 9'd256) ? 256 : int'(len);
    for (int i = 0; i < n; i++) bytes.push_back(i < preset.size() ? preset[i] : int'($urandom_range(255)));
    clear_log();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; length = len; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; k = 1;
    while (idx < n && k < 1200) begin
      in_valid = !(k >= stall_lo && k <= stall_hi) && ($urandom_range(99) >= stall_pct);
      in_data = 8'(bytes[idx]);
      if (poke && k == 2) begin start = 1'b1; base_addr = ~base; length = 9'd3; end
      @(negedge clk);
      if (k == 1) begin
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL error_cleared: error=%b need 0", error); end
      end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL in_ready_write: k=%0d in_ready=%b need 1", k, in_ready); end
      if (in_valid) begin acc_cyc.push_back(k); idx++; end
      @(posedge clk); #1;
      start = 1'b0;
      k++;
    end
    in_valid = 1'b1; in_data = 8'hEE;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL in_ready_full: in_ready=%b need 0", in_ready); end
    guard = 0;
    while (done_cyc.size() == 0 && guard < 1500) begin @(negedge clk); guard++; end
    in_valid = 1'b0;
    last_acc = (n > 0) ? acc_cyc[n-1] : 0;
    exp_done = (n == 0) ? 1 : last_acc + 2 + n;
    last_done_rel = (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1;
    total++;
    if (done_cyc.size() != 1 || last_done_rel != exp_done)
      begin bad++; $display("FAIL done_cycle: got %0d (pulses %0d) need %0d", last_done_rel, done_cyc.size(), exp_done); end
    total++;
    if (w_addr.size() != n) begin bad++; $display("FAIL write_count: got %0d need %0d", w_addr.size(), n); end
    for (int i = 0; i < n && i < w_addr.size(); i++) begin
      total++;
      if (w_addr[i] != ((int'(base) + i) & 255) || w_data[i] != bytes[i] || w_cyc[i] - t0 != acc_cyc[i] + 1) begin
        bad++;
        $display("FAIL write_%0d: addr=%h data=%h cyc=%0d need addr=%h data=%h cyc=%0d", i, w_addr[i], w_data[i],
                 w_cyc[i] - t0, (int'(base) + i) & 255, bytes[i], acc_cyc[i] + 1);
      end
    end
    total++;
    if (r_addr.size() != n) begin bad++; $display("FAIL read_count: got %0d need %0d", r_addr.size(), n); end
    for (int i = 0; i < n && i < r_addr.size(); i++) begin
      total++;
      if (r_addr[i] != ((int'(base) + i) & 255) || r_cyc[i] - t0 != last_acc + 2 + i) begin
        bad++;
        $display("FAIL read_%0d: addr=%h cyc=%0d need addr=%h cyc=%0d", i, r_addr[i], r_cyc[i] - t0,
                 (int'(base) + i) & 255, last_acc + 2 + i);
      end
    end
    total++;
    if (busy_cnt != exp_done - 1) begin bad++; $display("FAIL busy_span: got %0d cycles need %0d", busy_cnt, exp_done - 1); end
    ws = 0; rs = 0;
    for (int i = 0; i < n; i++) begin
      ws += bytes[i];
      rs += bytes[i] ^ int'(corrupt && ((int'(base) + i) & 255) == 8'h11);
    end
    exp_err = (n > 0) && ((ws & 255) != (rs & 255));
    total++;
    if (err_at_done !== exp_err) begin bad++; $display("FAIL error_at_done: got %b need %b", err_at_done, exp_err); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({mem_write_en, mem_read_en, mem_ce} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b need 000", {mem_write_en, mem_read_en, mem_ce}); end
    total++;
    if ({in_ready, busy, done, error} !== 4'b0000) begin bad++; $display("FAIL reset_status: got %b need 0000", {in_ready, busy, done, error}); end
    total++;
    if ({mem_address, mem_wdata} !== 16'h0000) begin bad++; $display("FAIL reset_bus: got %h need 0000", {mem_address, mem_wdata}); end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    preset = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_load(8'h10, 9'd4, -1, -1, 0, 1'b0);
    total++;
    if (last_done_rel != 10) begin bad++; $display("FAIL basic_done: got %0d need 10", last_done_rel); end
    preset.delete();
  endtask

  task automatic test_wrap();
    do_load(8'hFE, 9'd4, -1, -1, 0, 1'b0);
    total++;
    if (w_addr.size() != 4 || w_addr[2] != 0) begin bad++; $display("FAIL wrap_addr: got %0d need 0", w_addr[2]); end
  endtask

  task automatic test_stall();
    preset = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_load(8'h10, 9'd4, 2, 3, 0, 1'b0);
    total++;
    if (last_done_rel != 12) begin bad++; $display("FAIL stall_done: got %0d need 12", last_done_rel); end
    preset.delete();
  endtask

  task automatic test_corrupt();
    corrupt = 1'b1;
    do_load(8'h10, 9'd4, -1, -1, 0, 1'b0);
    total++;
    if (err_at_done !== 1'b1) begin bad++; $display("FAIL corrupt_error: got %b need 1", err_at_done); end
    repeat (5) @(negedge clk);
    total++;
    if (error !== 1'b1) begin bad++; $display("FAIL error_sticky: got %b need 1", error); end
    corrupt = 1'b0;
    do_load(8'h10, 9'd4, -1, -1, 0, 1'b0);
  endtask

  task automatic test_zero_len();
    do_load(8'h33, 9'd0, -1, -1, 0, 1'b0);
    total++;
    if (last_done_rel != 1) begin bad++; $display("FAIL zero_done: got %0d need 1", last_done_rel); end
  endtask

  task automatic test_clamp();
    bit seen[256];
    int dup;
    do_load(8'($urandom), 9'h1FF, -1, -1, 10, 1'b0);
    dup = 0;
    foreach (w_addr[i]) begin
      if (seen[w_addr[i]]) dup++;
      seen[w_addr[i]] = 1'b1;
    end
    total++;
    if (w_addr.size() != 256 || dup != 0) begin bad++; $display("FAIL clamp: writes=%0d dups=%0d need 256 and 0", w_addr.size(), dup); end
  endtask

  task automatic test_start_ignored();
    do_load(8'h40, 9'd6, -1, -1, 0, 1'b1);
  endtask

  task automatic test_reset_abort();
    clear_log();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h10; length = 9'd4;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
    @(posedge clk); #1;
    in_data = 8'hB2;
    @(posedge clk); #1;
    in_data = 8'hC3; reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_write_en, mem_read_en, mem_ce, in_ready, busy, done, error} !== 7'b0 || {mem_address, mem_wdata} !== 16'h0)
      begin bad++; $display("FAIL abort_outputs: got %b/%h need all 0", {mem_write_en, mem_read_en, mem_ce, in_ready, busy, done, error}, {mem_address, mem_wdata}); end
    repeat (6) @(negedge clk);
    total++;
    if (w_addr.size() != 2 || r_addr.size() != 0 || done_cyc.size() != 0)
      begin bad++; $display("FAIL abort_quiet: writes=%0d reads=%0d dones=%0d need 2 0 0", w_addr.size(), r_addr.size(), done_cyc.size()); end
    preset = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_load(8'h10, 9'd4, -1, -1, 0, 1'b0);
    total++;
    if (last_done_rel != 10) begin bad++; $display("FAIL abort_reload_done: got %0d need 10", last_done_rel); end
    preset.delete();
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++)
      do_load(8'($urandom), 9'($urandom_range(1, 24)), -1, -1, int'($urandom_range(0, 50)), 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_corrupt();
    test_zero_len();
    test_clamp();
    test_start_ignored();
    test_reset_abort();
    test_random();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
Sequential writer for the 256x8 memory family used across the design: ce, read_en, address, with the read data returned combinationally in the same cycle.
- Accepts a byte stream over a valid/ready handshake and writes the bytes to consecutive addresses starting at a programmable base.
- Optionally reads the written range back and compares a modulo-2^DATA_WIDTH checksum to verify the load.
- Sits between a byte source (host link, boot sequencer) and the memory.

Parameters:
ADDR_WIDTH, 8, memory address width; depth is 2^ADDR_WIDTH.
DATA_WIDTH, 8, memory word and stream byte width.
VERIFY, 1, 1 = read-back checksum pass after the write pass; 0 = skip it.

Ports:
clk  input  1  clock; all state changes on its rising edge
reset_n  input  1  reset; one clock, synchronous, active-low
start  input  1  begin a load; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first address; sampled with start
length  input  ADDR_WIDTH+1  number of bytes; sampled with start; values above 2^ADDR_WIDTH are clamped to 2^ADDR_WIDTH
in_data  input  DATA_WIDTH  stream byte
in_valid  input  1  in_data is valid
in_ready  output  1  loader accepts a byte this cycle
mem_address  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data, combinational from mem_address
mem_write_en  output  1  write strobe
mem_read_en  output  1  read strobe
mem_ce  output  1  chip enable; high whenever either strobe is high
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle completion pulse
error  output  1  checksum mismatch; sticky until the next accepted start

Behaviour:
- Reset (reset_n low at an edge): state IDLE; every output 0; counters, address register and checksums cleared. A reset during WRITE or VERIFY aborts the load immediately. No strobe is driven after that edge.
- All outputs are registered except in_ready, which is decoded from state and count.
- States: IDLE, WRITE, VERIFY, DONE.
- IDLE:
  - start=1 with clamped length N>0: capture base_addr and N; clear wcount, rcount, wsum, rsum and error; go to WRITE.
  - start=1 with N=0: go straight to DONE; no memory strobes are issued.
- WRITE:
  - in_ready = (wcount < N).
  - A byte is accepted when in_valid && in_ready.
  - The cycle after acceptance drives mem_write_en=1, mem_ce=1, mem_address = base+wcount (modulo 2^ADDR_WIDTH), mem_wdata = accepted byte.
  - On acceptance: wcount increments; wsum += byte (modulo 2^DATA_WIDTH).
  - Cycles without an accepted byte issue no strobe, and the address does not advance.
  - After the last accept, the state moves to VERIFY (VERIFY=1) or DONE (VERIFY=0) once the final write has been driven.
- VERIFY:
  - Each cycle: mem_read_en=1, mem_ce=1, mem_address = base+rcount (wrapping).
  - mem_rdata is sampled in the same cycle into rsum.
  - After N reads, go to DONE.
- DONE: for one cycle, done=1 and busy=0; error is set if VERIFY=1 and rsum != wsum. Next state is IDLE.
- Throughput: 1 byte/cycle.
- Latency with no stalls, start accepted in cycle 0:
  - accepts in cycles 1..N
  - writes in cycles 2..N+1
  - reads in cycles N+2..2N+1
  - done in cycle 2N+2 (N+2 when VERIFY=0)
- Simultaneous events:
  - start outside IDLE is ignored.
  - in_valid outside WRITE is ignored; in_ready is 0 there.
  - mem_write_en and mem_read_en are never high in the same cycle.
- length 2^ADDR_WIDTH with a non-zero base wraps and rewrites no address twice.

Decomposition:
- ram_loader_pkg: state enum (IDLE, WRITE, VERIFY, DONE); ADDR_WIDTH/DATA_WIDTH defaults; clamp helper function.
- One sub-module, ram_loader_sum: a DATA_WIDTH modulo accumulator with clear and enable, instantiated twice (wsum, rsum).

Test Plan:
1. base=8'h10, length=4, bytes A1 B2 C3 D4 with in_valid always high, correct memory model -> writes to 10,11,12,13 in cycles 2-5; reads in cycles 6-9; done in cycle 10; error=0.
2. base=8'hFE, length=4 -> write and read addresses FE, FF, 00, 01; error=0.
3. Same as test 1 with in_valid low in cycles 2 and 3 -> exactly 4 write strobes at consecutive addresses; done delayed by 2 cycles.
4. Memory model flips bit 0 on reads of address 8'h11 -> done pulse, error=1; error held until the next start, then cleared.
5. length=0 -> done in cycle 1; no mem_ce. length=9'h1FF -> clamped to 256 writes. start during WRITE -> ignored.
6. reset_n low in cycle 3 of test 1 -> the next edge leaves all outputs 0 and IDLE. A following start completes the load normally.
